// File: rtl/tinyml_cam_pkg.sv
// Shared types for the camera ROI crop block: coordinate width, decimation
// step codes, crop FSM states and the shadow ROI record.
package tinyml_cam_pkg;
  localparam int CW = 11;

  typedef logic [CW-1:0] coord_t;

  typedef enum logic [1:0] {
    STEP_1 = 2'd0,
    STEP_2 = 2'd1,
    STEP_4 = 2'd2,
    STEP_8 = 2'd3
  } step_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  typedef struct packed {
    coord_t xs;
    coord_t xw;
    coord_t ys;
    coord_t yw;
    step_e  xstep;
    step_e  ystep;
  } roi_t;

  // Low bits an ROI-relative offset must clear to sit on the decimation grid.
  function automatic coord_t step_mask(step_e s);
    case (s)
      STEP_1:  return coord_t'(0);
      STEP_2:  return coord_t'(1);
      STEP_4:  return coord_t'(3);
      default: return coord_t'(7);
    endcase
  endfunction
endpackage

// File: rtl/tinyml_cam_roi_crop_if.sv
// ROI configuration request bus: requester drives the window and update
// strobe, the shadow-register holder reports a pending request on busy.
interface tinyml_cam_roi_crop_if;
  import tinyml_cam_pkg::*;

  coord_t     x_start;
  coord_t     x_win;
  coord_t     y_start;
  coord_t     y_win;
  logic [1:0] x_step;
  logic [1:0] y_step;
  logic       update;
  logic       busy;

  modport master (output x_start, x_win, y_start, y_win, x_step, y_step, update,
                  input  busy);
  modport slave  (input  x_start, x_win, y_start, y_win, x_step, y_step, update,
                  output busy);
endinterface

// File: rtl/tinyml_cam_roi_cfg.sv
// Shadow ROI registers with a pending-request flag; a request is latched by
// the update strobe and applied only when the crop FSM allows it.
module tinyml_cam_roi_cfg
  import tinyml_cam_pkg::*;
#(
  parameter int X_START = 0,
  parameter int X_WIN   = 240,
  parameter int Y_START = 0,
  parameter int Y_WIN   = 540
) (
  input  logic                  in_pclk,
  input  logic                  in_arstn,
  tinyml_cam_roi_crop_if.slave  cfg,
  input  logic                  apply_ok,
  output roi_t                  roi
);
  logic pend_q, pend_d;
  logic apply;
  roi_t roi_q, roi_d;

  // cfg_* is sampled on the apply cycle, so extra strobes while pending only
  // refresh which values end up loaded.
  always_comb begin
    apply  = pend_q & apply_ok;
    pend_d = apply ? 1'b0 : (pend_q | cfg.update);
    roi_d  = roi_q;
    if (apply) begin
      roi_d.xs    = cfg.x_start;
      roi_d.xw    = cfg.x_win;
      roi_d.ys    = cfg.y_start;
      roi_d.yw    = cfg.y_win;
      roi_d.xstep = step_e'(cfg.x_step);
      roi_d.ystep = step_e'(cfg.y_step);
    end
  end

  always_ff @(posedge in_pclk or negedge in_arstn) begin
    if (!in_arstn) begin
      pend_q    <= 1'b0;
      roi_q.xs    <= coord_t'(X_START);
      roi_q.xw    <= coord_t'(X_WIN);
      roi_q.ys    <= coord_t'(Y_START);
      roi_q.yw    <= coord_t'(Y_WIN);
      roi_q.xstep <= STEP_1;
      roi_q.ystep <= STEP_1;
    end else begin
      pend_q <= pend_d;
      roi_q  <= roi_d;
    end
  end

  assign cfg.busy = pend_q;
  assign roi      = roi_q;
endmodule

// File: rtl/tinyml_cam_roi_crop.sv
// Camera ROI crop with power-of-two decimation: input register stage, crop
// FSM and decision logic, output register stage (2-cycle latency).
module tinyml_cam_roi_crop
  import tinyml_cam_pkg::*;
#(
  parameter int P_DEPTH = 10,
  parameter int P_CH    = 3,
  parameter int X_START = 0,
  parameter int X_WIN   = 240,
  parameter int Y_START = 0,
  parameter int Y_WIN   = 540
) (
  input  logic                      in_pclk,
  input  logic                      in_arstn,
  input  coord_t                    in_x,
  input  coord_t                    in_y,
  input  logic                      in_valid,
  input  logic [P_CH*P_DEPTH-1:0]   in_data,
  input  coord_t                    cfg_x_start,
  input  coord_t                    cfg_x_win,
  input  coord_t                    cfg_y_start,
  input  coord_t                    cfg_y_win,
  input  logic [1:0]                cfg_x_step,
  input  logic [1:0]                cfg_y_step,
  input  logic                      cfg_update,
  output logic                      cfg_busy,
  output coord_t                    out_x,
  output coord_t                    out_y,
  output logic                      out_valid,
  output logic                      out_hs,
  output logic                      out_sof,
  output logic                      out_eof,
  output logic [P_CH*P_DEPTH-1:0]   out_data
);
  localparam int DW = P_CH * P_DEPTH;

  tinyml_cam_roi_crop_if cfg_bus ();
  assign cfg_bus.x_start = cfg_x_start;
  assign cfg_bus.x_win   = cfg_x_win;
  assign cfg_bus.y_start = cfg_y_start;
  assign cfg_bus.y_win   = cfg_y_win;
  assign cfg_bus.x_step  = cfg_x_step;
  assign cfg_bus.y_step  = cfg_y_step;
  assign cfg_bus.update  = cfg_update;
  assign cfg_busy        = cfg_bus.busy;

  roi_t   roi;
  state_e state_q, state_d;

  tinyml_cam_roi_cfg #(
    .X_START (X_START),
    .X_WIN   (X_WIN),
    .Y_START (Y_START),
    .Y_WIN   (Y_WIN)
  ) u_cfg (
    .in_pclk  (in_pclk),
    .in_arstn (in_arstn),
    .cfg      (cfg_bus.slave),
    .apply_ok (state_d == ST_IDLE),
    .roi      (roi)
  );

  coord_t          s1_x_q, s1_x_d, s1_y_q, s1_y_d;
  logic            s1_vld_q, s1_vld_d;
  logic [DW-1:0]   s1_data_q, s1_data_d;

  logic [CW:0]     x_end, y_end;
  coord_t          dx, dy;
  logic [1:0]      xsh, ysh;
  logic            x_in, y_in, col_ok, row_ok, enabled;
  logic            is_start, is_end, is_zero, enter, in_frame, abort, done, accept;

  coord_t          out_x_q, out_x_d, out_y_q, out_y_d;
  logic [DW-1:0]   out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d, out_hs_q, out_hs_d;
  logic            out_sof_q, out_sof_d, out_eof_q, out_eof_d;
  logic            eof_pend_q, eof_pend_d;

  always_comb begin
    s1_x_d    = in_x;
    s1_y_d    = in_y;
    s1_vld_d  = in_valid;
    s1_data_d = in_data;
  end

  // 12-bit window ends so an ROI hanging off the sensor never wraps around.
  always_comb begin
    x_end    = {1'b0, roi.xs} + {1'b0, roi.xw} - 12'd1;
    y_end    = {1'b0, roi.ys} + {1'b0, roi.yw} - 12'd1;
    dx       = s1_x_q - roi.xs;
    dy       = s1_y_q - roi.ys;
    xsh      = roi.xstep;
    ysh      = roi.ystep;
    x_in     = (s1_x_q >= roi.xs) && ({1'b0, s1_x_q} <= x_end);
    y_in     = (s1_y_q >= roi.ys) && ({1'b0, s1_y_q} <= y_end);
    col_ok   = x_in && ((dx & step_mask(roi.xstep)) == '0);
    row_ok   = y_in && ((dy & step_mask(roi.ystep)) == '0);
    enabled  = (roi.xw != '0) && (roi.yw != '0);
    is_start = s1_vld_q && (s1_x_q == roi.xs) && (s1_y_q == roi.ys) && enabled;
    is_end   = s1_vld_q && ({1'b0, s1_x_q} == x_end) && ({1'b0, s1_y_q} == y_end);
    is_zero  = s1_vld_q && (s1_x_q == '0) && (s1_y_q == '0);
    enter    = (state_q == ST_IDLE) && is_start;
    in_frame = (state_q == ST_ACTIVE) || enter;
    abort    = (state_q == ST_ACTIVE) && is_zero;
    done     = in_frame && (is_end || abort);
    accept   = in_frame && s1_vld_q && col_ok && row_ok;

    state_d = state_q;
    if (done)       state_d = (abort && is_start) ? ST_ACTIVE : ST_IDLE;
    else if (enter) state_d = ST_ACTIVE;

    out_valid_d = accept;
    out_hs_d    = in_frame && x_in && row_ok;
    out_sof_d   = accept && (dx == '0) && (dy == '0);
    out_x_d     = accept ? (dx >> xsh) : out_x_q;
    out_y_d     = accept ? (dy >> ysh) : out_y_q;
    out_data_d  = accept ? s1_data_q : out_data_q;
    eof_pend_d  = done;
    out_eof_d   = eof_pend_q;
  end

  always_ff @(posedge in_pclk or negedge in_arstn) begin
    if (!in_arstn) begin
      s1_x_q      <= '0;
      s1_y_q      <= '0;
      s1_vld_q    <= 1'b0;
      s1_data_q   <= '0;
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_hs_q    <= 1'b0;
      out_sof_q   <= 1'b0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_data_q  <= '0;
      eof_pend_q  <= 1'b0;
      out_eof_q   <= 1'b0;
    end else begin
      s1_x_q      <= s1_x_d;
      s1_y_q      <= s1_y_d;
      s1_vld_q    <= s1_vld_d;
      s1_data_q   <= s1_data_d;
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_hs_q    <= out_hs_d;
      out_sof_q   <= out_sof_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
      out_data_q  <= out_data_d;
      eof_pend_q  <= eof_pend_d;
      out_eof_q   <= out_eof_d;
    end
  end

  assign out_x     = out_x_q;
  assign out_y     = out_y_q;
  assign out_valid = out_valid_q;
  assign out_hs    = out_hs_q;
  assign out_sof   = out_sof_q;
  assign out_eof   = out_eof_q;
  assign out_data  = out_data_q;
endmodule

// File: tb/tb_tinyml_cam_roi_crop.sv
// Scoreboard bench for tinyml_cam_roi_crop: random pixel gaps and data, a
// frame-level ROI model feeding an expected-output queue, and a monitor.
module tb_tinyml_cam_roi_crop;
  localparam int DW    = 30;
  // Reset-default window runs at 1/10 scale (24x54 in a 64x54 frame).
  localparam int TB_XW = 24;
  localparam int TB_YW = 54;

  logic          in_pclk, in_arstn, in_valid;
  logic [10:0]   in_x, in_y, out_x, out_y;
  logic [DW-1:0] in_data, out_data;
  logic          out_valid, out_hs, out_sof, out_eof;

  tinyml_cam_roi_crop_if cfg_bus ();

  tinyml_cam_roi_crop #(
    .P_DEPTH(10), .P_CH(3), .X_START(0), .X_WIN(TB_XW), .Y_START(0), .Y_WIN(TB_YW)
  ) dut (
    .in_pclk     (in_pclk),
    .in_arstn    (in_arstn),
    .in_x        (in_x),
    .in_y        (in_y),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .cfg_x_start (cfg_bus.x_start),
    .cfg_x_win   (cfg_bus.x_win),
    .cfg_y_start (cfg_bus.y_start),
    .cfg_y_win   (cfg_bus.y_win),
    .cfg_x_step  (cfg_bus.x_step),
    .cfg_y_step  (cfg_bus.y_step),
    .cfg_update  (cfg_bus.update),
    .cfg_busy    (cfg_bus.busy),
    .out_x       (out_x),
    .out_y       (out_y),
    .out_valid   (out_valid),
    .out_hs      (out_hs),
    .out_sof     (out_sof),
    .out_eof     (out_eof),
    .out_data    (out_data)
  );

  initial in_pclk = 1'b0;
  always #5 in_pclk = ~in_pclk;

  typedef struct {
    int            ox;
    int            oy;
    logic [DW-1:0] d;
    bit            sof;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vec, bad;
  int   n_valid, n_sof, n_eof, max_x, max_y, m_pushed;

  // reference ROI state and the cfg values currently presented on the bus
  int m_xs, m_xw, m_ys, m_yw, m_xst, m_yst;
  int c_xs, c_xw, c_ys, c_yw, c_xst, c_yst;
  bit m_act, m_pend;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_defaults();
    m_xs = 0; m_xw = TB_XW; m_ys = 0; m_yw = TB_YW; m_xst = 0; m_yst = 0;
    m_act = 0; m_pend = 0;
  endtask

  task automatic model_apply();
    m_xs = c_xs; m_xw = c_xw; m_ys = c_ys; m_yw = c_yw; m_xst = c_xst; m_yst = c_yst;
  endtask

  task automatic model_update();
    if (m_act) m_pend = 1;
    else       model_apply();
  endtask

  // One sensor pixel against the ROI rules: window membership, stride grid,
  // frame start at the window corner, frame end at the far corner or (0,0).
  task automatic model_px(int x, int y, logic [DW-1:0] d);
    bit start, last, origin, was;
    int sx, sy;
    exp_t e;
    sx     = 1 << m_xst;
    sy     = 1 << m_yst;
    start  = (x == m_xs) && (y == m_ys) && (m_xw != 0) && (m_yw != 0);
    last   = (x == m_xs + m_xw - 1) && (y == m_ys + m_yw - 1);
    origin = (x == 0) && (y == 0);
    was    = m_act;
    if (start) m_act = 1;
    if (m_act && x >= m_xs && x < m_xs + m_xw && y >= m_ys && y < m_ys + m_yw &&
        (x - m_xs) % sx == 0 && (y - m_ys) % sy == 0) begin
      e.ox  = (x - m_xs) / sx;
      e.oy  = (y - m_ys) / sy;
      e.d   = d;
      e.sof = (x == m_xs) && (y == m_ys);
      exp_q.push_back(e);
      m_pushed++;
    end
    if (m_act && (last || (was && origin))) begin
      m_act = was && origin && start;
      if (!m_act && m_pend) begin
        model_apply();
        m_pend = 0;
      end
    end
  endtask

  task automatic idle(int n);
    in_valid = 1'b0;
    repeat (n) @(posedge in_pclk);
    #1;
  endtask

  task automatic px(int x, int y);
    logic [DW-1:0] d;
    if ($urandom_range(0, 7) == 0) idle(1);
    d        = DW'($urandom);
    in_x     = 11'(x);
    in_y     = 11'(y);
    in_data  = d;
    in_valid = 1'b1;
    model_px(x, y, d);
    @(posedge in_pclk);
    #1;
    in_valid       = 1'b0;
    cfg_bus.update = 1'b0;
  endtask

  task automatic frame(int w, int h);
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++) px(x, y);
  endtask

  task automatic set_cfg(int xs, int xw, int ys, int yw, int xst, int yst);
    c_xs = xs; c_xw = xw; c_ys = ys; c_yw = yw; c_xst = xst; c_yst = yst;
    cfg_bus.x_start = 11'(xs);
    cfg_bus.x_win   = 11'(xw);
    cfg_bus.y_start = 11'(ys);
    cfg_bus.y_win   = 11'(yw);
    cfg_bus.x_step  = 2'(xst);
    cfg_bus.y_step  = 2'(yst);
    cfg_bus.update  = 1'b1;
    idle(1);
    cfg_bus.update  = 1'b0;
    model_update();
    idle(3);
  endtask

  task automatic clr();
    n_valid = 0; n_sof = 0; n_eof = 0; max_x = 0; max_y = 0; m_pushed = 0;
  endtask

  task automatic drain(string nm);
    idle(5);
    chk({nm, " scoreboard drained"}, exp_q.size(), 0);
  endtask

  always @(negedge in_pclk) begin
    if (in_arstn) begin
      if (out_valid) begin
        n_valid++;
        if (int'(out_x) > max_x) max_x = int'(out_x);
        if (int'(out_y) > max_y) max_y = int'(out_y);
        if (out_sof) n_sof++;
        chk("output expected by model", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("out_x", out_x, mon_e.ox);
          chk("out_y", out_y, mon_e.oy);
          chk("out_data", out_data, mon_e.d);
          chk("out_sof", out_sof, mon_e.sof);
          chk("out_hs with valid", out_hs, 1);
        end
      end else begin
        chk("out_sof while idle", out_sof, 0);
      end
      if (out_eof) begin
        n_eof++;
        chk("out_valid with eof", out_valid, 0);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad + 1);
    $fatal(1, "timeout");
  end

  int ref_cnt;

  initial begin
    vec = 0; bad = 0;
    in_arstn = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; in_data = '0;
    cfg_bus.x_start = '0; cfg_bus.x_win = '0; cfg_bus.y_start = '0; cfg_bus.y_win = '0;
    cfg_bus.x_step = '0; cfg_bus.y_step = '0; cfg_bus.update = 1'b0;
    model_defaults();
    clr();
    repeat (3) @(posedge in_pclk);
    #1;
    chk("reset out_valid", out_valid, 0);
    chk("reset out_data", out_data, 0);
    chk("reset out_x", out_x, 0);
    chk("reset out_eof", out_eof, 0);
    chk("reset cfg_busy", cfg_bus.busy, 0);
    @(negedge in_pclk) in_arstn = 1'b1;
    @(posedge in_pclk);
    #1;

    // reset-default window
    clr();
    frame(64, 54);
    drain("default");
    chk("default count", n_valid, TB_XW * TB_YW);
    chk("default max out_x", max_x, TB_XW - 1);
    chk("default sof", n_sof, 1);
    chk("default eof", n_eof, 1);

    // 64x32 window at (100,20), stride 2 both ways
    clr();
    set_cfg(100, 64, 20, 32, 1, 1);
    frame(170, 55);
    drain("stride2");
    chk("stride2 count", n_valid, 512);
    chk("stride2 max out_x", max_x, 31);
    chk("stride2 max out_y", max_y, 15);
    chk("stride2 eof", n_eof, 1);

    // update mid-frame: old window completes, new one takes the next frame
    clr();
    for (int y = 0; y < 55; y++)
      for (int x = 0; x < 170; x++) begin
        if (x == 80 && y == 25) begin
          c_xs = $urandom_range(0, 40); c_xw = $urandom_range(1, 60);
          c_ys = $urandom_range(0, 20); c_yw = $urandom_range(1, 30);
          c_xst = $urandom_range(0, 3); c_yst = $urandom_range(0, 3);
          cfg_bus.x_start = 11'(c_xs); cfg_bus.x_win = 11'(c_xw);
          cfg_bus.y_start = 11'(c_ys); cfg_bus.y_win = 11'(c_yw);
          cfg_bus.x_step = 2'(c_xst); cfg_bus.y_step = 2'(c_yst);
          cfg_bus.update = 1'b1;
        end
        if (x == 163 && y == 51) chk("cfg_busy held to end corner", cfg_bus.busy, 1);
        px(x, y);
        if (x == 80 && y == 25) model_update();
      end
    drain("midupd old");
    chk("midupd cfg_busy released", cfg_bus.busy, 0);
    chk("midupd old count", n_valid, 512);
    chk("midupd old eof", n_eof, 1);
    clr();
    frame(170, 55);
    ref_cnt = m_pushed;
    drain("midupd new");
    chk("midupd new count", n_valid, ref_cnt);
    chk("midupd new sof", n_sof, 1);
    chk("midupd new eof", n_eof, 1);

    // window hangs past a 640-wide sensor edge: ended only by (0,0)
    clr();
    set_cfg(600, 100, 1, 3, 0, 0);
    frame(640, 4);
    frame(640, 4);
    px(0, 0);
    drain("edge");
    chk("edge count", n_valid, 240);
    chk("edge max out_x", max_x, 39);
    chk("edge sof", n_sof, 2);
    chk("edge eof", n_eof, 2);

    // zero width disables the block
    clr();
    set_cfg(0, 0, 0, 54, 0, 0);
    frame(64, 54);
    drain("zero width");
    chk("zero width valid", n_valid, 0);
    chk("zero width sof", n_sof, 0);
    chk("zero width eof", n_eof, 0);

    // reset inside the window at (150,30)
    clr();
    set_cfg(100, 64, 20, 32, $urandom_range(0, 3), $urandom_range(0, 3));
    for (int y = 0; y < 40; y++)
      for (int x = 0; x < 170; x++) begin
        px(x, y);
        if (x == 150 && y == 30) begin
          #2 in_arstn = 1'b0;
          #1;
          chk("midreset out_valid", out_valid, 0);
          chk("midreset out_data", out_data, 0);
          chk("midreset out_x", out_x, 0);
          chk("midreset out_y", out_y, 0);
          chk("midreset out_hs", out_hs, 0);
          exp_q.delete();
          model_defaults();
          repeat (2) @(posedge in_pclk);
          @(negedge in_pclk) in_arstn = 1'b1;
          @(posedge in_pclk);
          #1;
          clr();
        end
      end
    drain("post-reset tail");
    chk("post-reset tail valid", n_valid, 0);
    chk("post-reset tail eof", n_eof, 0);
    clr();
    frame(64, 54);
    drain("post-reset frame");
    chk("post-reset count", n_valid, TB_XW * TB_YW);
    chk("post-reset sof", n_sof, 1);
    chk("post-reset eof", n_eof, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule

// File: doc/tinyml_cam_roi_crop.md
TINYML_CAM_ROI_CROP -- requirements
Module: tinyml_cam_roi_crop

Interface
REQ-001 Parameters SHALL be: P_DEPTH, default 10, bits per channel; P_CH, default 3, channels per pixel; X_START, default 0, reset x origin; X_WIN, default 240, reset width; Y_START, default 0, reset y origin; Y_WIN, default 540, reset height.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low; ports SHALL be named in_pclk and in_arstn.
REQ-003 Ports SHALL be, in order:
- in_pclk in 1: pixel clock.
- in_arstn in 1: async active-low reset.
- in_x, in_y in 11 each: sensor coordinates.
- in_valid in 1: pixel strobe.
- in_data in P_CH*P_DEPTH: packed pixel, channel 0 in the LSBs.
- cfg_x_start, cfg_x_win, cfg_y_start, cfg_y_win in 11 each: ROI request.
- cfg_x_step, cfg_y_step in 2 each: decimation code; 0/1/2/3 selects stride 1/2/4/8.
- cfg_update in 1: one-cycle request to load cfg_*.
- cfg_busy out 1: a request is pending.
- out_x, out_y out 11 each: decimated ROI coordinates.
- out_valid out 1: output pixel strobe.
- out_hs out 1: high while the current row lies inside the ROI columns.
- out_sof out 1: one-cycle pulse with the first ROI pixel.
- out_eof out 1: one-cycle pulse at the end of the ROI.
- out_data out P_CH*P_DEPTH: cropped pixel.

Function
REQ-004 Shadow ROI registers (xs, xw, ys, yw, xstep, ystep) SHALL drive all crop decisions; they are never written directly from cfg_* ports.
REQ-005 A cfg_update pulse SHALL set a pending flag, and cfg_busy SHALL equal that flag.
REQ-006 In IDLE, a pending request SHALL load the cfg_* values into the shadow registers one cycle later and clear the flag.
REQ-007 In ACTIVE, a pending request SHALL be applied on the cycle the FSM returns to IDLE.
REQ-008 Repeated cfg_update pulses while pending SHALL be absorbed; the cfg_* values sampled are those present on the apply cycle.
REQ-009 The FSM SHALL have two states, IDLE and ACTIVE.
REQ-010 IDLE→ACTIVE SHALL occur on a valid input pixel with in_x==xs and in_y==ys, provided xw!=0 and yw!=0; a zero width or height leaves the block disabled in IDLE.
REQ-011 ACTIVE→IDLE SHALL occur on a valid pixel at (xs+xw-1, ys+yw-1), or on a valid pixel at (0,0) that is not the start corner (frame abort).
REQ-012 If an abort pixel is itself the start corner, the FSM SHALL re-enter ACTIVE in the same transition.
REQ-013 A pixel SHALL be accepted when ACTIVE (including its entry pixel), in_valid=1, xs≤in_x≤xs+xw-1, ys≤in_y≤ys+yw-1, and the low xstep/ystep bits of (in_x-xs)/(in_y-ys) are zero.
REQ-014 For an accepted pixel: out_x=(in_x-xs)>>xstep; out_y=(in_y-ys)>>ystep; out_data is the input data; out_valid=1.
REQ-015 Latency SHALL be exactly 2 in_pclk cycles from the input to out_valid/out_data/out_x/out_y, implemented as an input register stage plus an output register stage.
REQ-016 For non-accepted cycles, out_valid=0 and out_data holds its last value; it is not zeroed.
REQ-017 out_hs SHALL be 1, aligned with out_valid timing, for every cycle whose registered x lies in the column range of an accepted row while ACTIVE.
REQ-018 out_sof SHALL assert with the out_valid of pixel (0,0).
REQ-019 out_eof SHALL pulse one cycle after the output of the end-corner or abort pixel, with out_valid=0.
REQ-020 Range comparisons SHALL use 12-bit sums so that xs+xw never wraps; an ROI extending past the sensor edge is terminated only by abort.

Reset
REQ-021 On in_arstn=0, the following SHALL clear asynchronously: all outputs (to 0), the pipeline registers, the pending flag, and the FSM (to IDLE).
REQ-022 On in_arstn=0, the shadow registers SHALL load X_START, X_WIN, Y_START, Y_WIN, step codes 0.
REQ-023 Reset asserted mid-frame SHALL emit no out_eof.
REQ-024 After release, the block SHALL wait for the next start corner.

Structure
REQ-025 Step encodings, the FSM state encodings and the 11-bit coordinate width SHALL live in the shared package tinyml_cam_pkg.
REQ-026 The shadow/pending logic SHALL be one sub-module, tinyml_cam_roi_cfg.
REQ-027 The FSM and datapath SHALL remain in the top module.

Verification
REQ-028 Reset defaults, 640x540 frame: the bench SHALL see 240x540 valid outputs, out_sof once, out_eof once, and out_x max 239.
REQ-029 cfg 100/64/20/32, steps 1/1, applied in IDLE: the bench SHALL see 32x16 outputs, first at out_x=0,out_y=0 from in(100,20), last at out_x=31,out_y=15 from in(162,50).
REQ-030 cfg_update mid-frame: cfg_busy SHALL stay 1 until the end corner, and the current frame SHALL complete with the old ROI; the next frame SHALL use the new ROI.
REQ-031 ROI 600/100 on a 640-wide sensor: output SHALL be limited to x 600..639, and the next (0,0) pixel SHALL produce out_eof plus a clean restart.
REQ-032 cfg_x_win=0: the bench SHALL see no out_valid, out_sof or out_eof for a full frame.
REQ-033 Reset asserted at pixel (150,30) inside the ROI: all outputs SHALL go to 0 immediately, and output SHALL resume only at the next start corner.
